// File: rtl/cmd_queue_pkg.sv
// Shared types for the command queue: the cmd_t record seen by host and issuer,
// and the writeback FSM states.
package cmd_queue_pkg;

  localparam int unsigned PROC_COUNT = 4;
  localparam int unsigned ID_W       = 8;
  localparam int unsigned REG_W      = 5;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [ID_W-1:0]  dep;
    logic [3:0]       opcode;
    logic [REG_W-1:0] src_a;
    logic [REG_W-1:0] src_b;
    logic [REG_W-1:0] dst;
  } cmd_t;

  localparam int unsigned CMD_W = $bits(cmd_t);

  typedef enum logic [1:0] {
    StIdle,
    StWbPend,
    StAck
  } wb_state_t;

endpackage

// File: rtl/cmd_queue_mem.sv
// DEPTH x cmd_t register file: one synchronous write port, one asynchronous read port.
module cmd_queue_mem
  import cmd_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  cmd_t             wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output cmd_t             rdata_o
);

  cmd_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cmd_queue.sv
// Circular command FIFO feeding the issuer, with one slot held back for issuer writebacks.
// Optional statistics outputs are built when CMD_QUEUE_STATS_EN is defined.
module cmd_queue
  import cmd_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           i_host_valid,
  input  cmd_t           i_host_cmd,
  output logic           o_host_ready,
  input  logic           i_read,
  input  logic           i_write,
  input  cmd_t           i_cmd,
  output cmd_t           o_cmd,
  output logic           o_empty,
  output logic           o_ack,
  output logic [PTR_W:0] o_count,
  output logic           o_underflow
`ifdef CMD_QUEUE_STATS_EN
  ,
  output logic [31:0]    o_wb_total,
  output logic [PTR_W:0] o_max_count
`endif
);

  localparam logic [PTR_W:0] FullCnt = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] HostMax = (PTR_W + 1)'(DEPTH - 1);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  wb_state_t        state_q, state_d;
  cmd_t             wb_q, wb_d;
  logic             underflow_q, underflow_d;
  logic             ready_en_q;

  logic empty, pop, slot_free, host_push, wb_push, mem_we;
  cmd_t wb_data, mem_wdata, mem_rdata;

  always_comb begin
    empty        = (count_q == '0);
    pop          = i_read && !empty;
    // A pop on the same edge frees the slot the writeback lands in.
    slot_free    = (count_q < FullCnt) || pop;
    o_host_ready = ready_en_q && (count_q < HostMax) && (state_q == StIdle) && !i_write;
    host_push    = i_host_valid && o_host_ready;
  end

  always_comb begin
    state_d = state_q;
    wb_d    = wb_q;
    wb_push = 1'b0;
    wb_data = i_cmd;
    unique case (state_q)
      StIdle: begin
        if (i_write) begin
          if (slot_free) begin
            wb_push = 1'b1;
            state_d = StAck;
          end else begin
            wb_d    = i_cmd;
            state_d = StWbPend;
          end
        end
      end
      StWbPend: begin
        wb_data = wb_q;
        if (slot_free) begin
          wb_push = 1'b1;
          state_d = StAck;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_we      = host_push || wb_push;
    mem_wdata   = wb_push ? wb_data : i_host_cmd;
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d    = wr_ptr_q + PTR_W'(mem_we);
    count_d     = count_q + (PTR_W + 1)'(mem_we) - (PTR_W + 1)'(pop);
    underflow_d = underflow_q || (i_read && empty);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= StIdle;
      wb_q        <= '0;
      underflow_q <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      wb_q        <= wb_d;
      underflow_q <= underflow_d;
      ready_en_q  <= 1'b1;
    end
  end

  cmd_queue_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk_i  (i_clk),
    .we_i   (mem_we),
    .waddr_i(wr_ptr_q),
    .wdata_i(mem_wdata),
    .raddr_i(rd_ptr_q),
    .rdata_o(mem_rdata)
  );

  // Gate the head so uninitialised storage never shows while empty.
  assign o_cmd       = empty ? '0 : mem_rdata;
  assign o_empty     = empty;
  assign o_ack       = (state_q == StAck);
  assign o_count     = count_q;
  assign o_underflow = underflow_q;

`ifdef CMD_QUEUE_STATS_EN
  logic [31:0]    wb_total_q, wb_total_d;
  logic [PTR_W:0] max_count_q, max_count_d;

  always_comb begin
    wb_total_d  = (wb_push && (wb_total_q != '1)) ? wb_total_q + 32'd1 : wb_total_q;
    max_count_d = (count_d > max_count_q) ? count_d : max_count_q;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wb_total_q  <= '0;
      max_count_q <= '0;
    end else begin
      wb_total_q  <= wb_total_d;
      max_count_q <= max_count_d;
    end
  end

  assign o_wb_total  = wb_total_q;
  assign o_max_count = max_count_q;
`endif

endmodule

// File: tb/tb_cmd_queue.sv
// Directed bench for cmd_queue: a queue-based model checked every cycle plus literal
// expectations. Define CMD_QUEUE_STATS_EN to also cover the statistics outputs.
module tb_cmd_queue;
  import cmd_queue_pkg::*;

  localparam int DEPTH = 16;
  localparam int PTR_W = $clog2(DEPTH);

  logic           clk = 1'b0;
  logic           rstn = 1'b1;
  logic           host_valid = 1'b0;
  cmd_t           host_cmd = '0;
  logic           host_ready;
  logic           rd = 1'b0;
  logic           wr = 1'b0;
  cmd_t           wcmd = '0;
  cmd_t           head;
  logic           empty, ack, underflow;
  logic [PTR_W:0] count;
`ifdef CMD_QUEUE_STATS_EN
  logic [31:0]    wb_total;
  logic [PTR_W:0] max_count;
`endif

  int total = 0;
  int bad = 0;

  cmd_queue #(.DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_host_valid(host_valid),
    .i_host_cmd  (host_cmd),
    .o_host_ready(host_ready),
    .i_read      (rd),
    .i_write     (wr),
    .i_cmd       (wcmd),
    .o_cmd       (head),
    .o_empty     (empty),
    .o_ack       (ack),
    .o_count     (count),
    .o_underflow (underflow)
`ifdef CMD_QUEUE_STATS_EN
    ,
    .o_wb_total  (wb_total),
    .o_max_count (max_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: queue contents, pending writeback, ack-due flag.
  cmd_t mq[$];
  bit   m_pend = 0;
  cmd_t m_pend_cmd = '0;
  bit   m_ack = 0;
  bit   m_ready_en = 0;
  bit   m_uf = 0;
  int   m_wb_total = 0;
  int   m_max = 0;

  function automatic cmd_t mk(input logic [7:0] id);
    cmd_t c;
    c.id     = id;
    c.dep    = id ^ 8'h5a;
    c.opcode = id[3:0];
    c.src_a  = id[4:0];
    c.src_b  = ~id[4:0];
    c.dst    = id[6:2];
    return c;
  endfunction

  function automatic bit exp_ready();
    return m_ready_en && (mq.size() < DEPTH - 1) && !m_pend && !m_ack && !wr;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit   pop, host, wb;
    cmd_t wb_cmd;
    int   n;
    if (!rstn) begin
      mq.delete();
      m_pend = 0; m_ack = 0; m_ready_en = 0; m_uf = 0;
      m_wb_total = 0; m_max = 0;
      return;
    end
    n      = mq.size();
    pop    = rd && (n > 0);
    host   = host_valid && exp_ready();
    wb     = 0;
    wb_cmd = '0;
    if (rd && n == 0) m_uf = 1;
    if (m_ack) begin
      m_ack = 0;
    end else if (m_pend) begin
      if (n < DEPTH || pop) begin
        wb = 1; wb_cmd = m_pend_cmd; m_pend = 0; m_ack = 1;
      end
    end else if (wr) begin
      if (n < DEPTH || pop) begin
        wb = 1; wb_cmd = wcmd; m_ack = 1;
      end else begin
        m_pend = 1; m_pend_cmd = wcmd;
      end
    end
    if (pop) void'(mq.pop_front());
    if (host) mq.push_back(host_cmd);
    if (wb) begin
      mq.push_back(wb_cmd);
      m_wb_total++;
    end
    if (mq.size() > m_max) m_max = mq.size();
    m_ready_en = 1;
  endtask

  initial forever begin
    @(posedge clk or negedge rstn);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("m_empty", 64'(empty), 64'(mq.size() == 0));
    chk("m_count", 64'(count), 64'(mq.size()));
    chk("m_ack", 64'(ack), 64'(m_ack));
    chk("m_underflow", 64'(underflow), 64'(m_uf));
    chk("m_host_ready", 64'(host_ready), 64'(exp_ready()));
    if (mq.size() != 0) chk("m_head", 64'(head), 64'(mq[0]));
`ifdef CMD_QUEUE_STATS_EN
    chk("m_wb_total", 64'(wb_total), 64'(m_wb_total));
    chk("m_max_count", 64'(max_count), 64'(m_max));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_host(input int n, input int first_id);
    for (int i = 0; i < n; i++) begin
      host_valid = 1'b1;
      host_cmd   = mk(8'(first_id + i));
      tick();
    end
    host_valid = 1'b0;
  endtask

  task automatic writeback(input logic [7:0] id);
    wr   = 1'b1;
    wcmd = mk(id);
    tick();
    wr   = 1'b0;
  endtask

  task automatic pop_n(input int n, output logic [7:0] last_id);
    last_id = '0;
    for (int i = 0; i < n; i++) begin
      last_id = head.id;
      rd = 1'b1;
      tick();
    end
    rd = 1'b0;
  endtask

  initial begin
    logic [7:0] last;
    #1 rstn = 1'b0;
    repeat (2) tick();
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_underflow", 64'(underflow), 64'd0);
    chk("rst_cmd", 64'(head), 64'd0);
    rstn = 1'b1;
    chk("ready_first_cycle", 64'(host_ready), 64'd0);
    tick();
    chk("ready_after", 64'(host_ready), 64'd1);

    // Basic ordering
    push_host(3, 1);
    chk("t1_count", 64'(count), 64'd3);
    chk("t1_head", 64'(head.id), 64'd1);
    for (int i = 1; i <= 3; i++) begin
      chk("t1_pop_id", 64'(head.id), 64'(i));
      rd = 1'b1;
      tick();
    end
    rd = 1'b0;
    chk("t1_empty", 64'(empty), 64'd1);

    // Reserved slot used by writeback
    push_host(15, 10);
    chk("t2_ready_low", 64'(host_ready), 64'd0);
    writeback(8'd99);
    chk("t2_ack", 64'(ack), 64'd1);
    chk("t2_count", 64'(count), 64'd16);
    tick();
    chk("t2_ack_gone", 64'(ack), 64'd0);
    pop_n(16, last);
    chk("t2_last_id", 64'(last), 64'd99);

    // Writeback while full waits for a pop
    push_host(15, 60);
    writeback(8'd50);
    tick();
    writeback(8'd7);
    chk("t3_no_ack", 64'(ack), 64'd0);
    chk("t3_count", 64'(count), 64'd16);
    tick();
    chk("t3_still_no_ack", 64'(ack), 64'd0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("t3_ack", 64'(ack), 64'd1);
    chk("t3_count_full", 64'(count), 64'd16);
    chk("t3_head", 64'(head.id), 64'd61);
    tick();
    pop_n(16, last);
    chk("t3_last_id", 64'(last), 64'd7);

    // Simultaneous pop and push at count 1, then pointer wrap
    push_host(1, 200);
    rd = 1'b1; host_valid = 1'b1; host_cmd = mk(8'd201);
    tick();
    chk("t4_count", 64'(count), 64'd1);
    chk("t4_head", 64'(head.id), 64'd201);
    for (int i = 0; i < 40; i++) begin
      host_cmd = mk(8'(100 + i));
      tick();
    end
    rd = 1'b0; host_valid = 1'b0;
    chk("t4_wrap_head", 64'(head.id), 64'd139);
    chk("t4_wrap_count", 64'(count), 64'd1);
    pop_n(1, last);

    // Underflow and reset during a pending writeback
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("t5_underflow", 64'(underflow), 64'd1);
    chk("t5_count", 64'(count), 64'd0);
    repeat (2) tick();
    chk("t5_underflow_sticky", 64'(underflow), 64'd1);
    push_host(15, 80);
    writeback(8'd40);
    tick();
    writeback(8'd33);
    chk("t5_pend_no_ack", 64'(ack), 64'd0);
    rstn = 1'b0;
    #1;
    chk("t5_rst_count", 64'(count), 64'd0);
    chk("t5_rst_empty", 64'(empty), 64'd1);
    chk("t5_rst_ack", 64'(ack), 64'd0);
    chk("t5_rst_underflow", 64'(underflow), 64'd0);
    chk("t5_rst_ready", 64'(host_ready), 64'd0);
    chk("t5_rst_cmd", 64'(head), 64'd0);
    repeat (3) tick();
    rstn = 1'b1;
    chk("t5_ready_first", 64'(host_ready), 64'd0);
    repeat (2) tick();
    chk("t5_no_late_ack", 64'(ack), 64'd0);

`ifdef CMD_QUEUE_STATS_EN
    push_host(11, 1);
    writeback(8'd200);
    tick();
    pop_n(12, last);
    for (int i = 0; i < 4; i++) begin
      writeback(8'(210 + i));
      rd = 1'b1;
      tick();
      rd = 1'b0;
    end
    tick();
    chk("t6_wb_total", 64'(wb_total), 64'd5);
    chk("t6_max_count", 64'(max_count), 64'd12);
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
